// File: rtl/uart_arb_pkg.sv
// Shared types and widths for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_ACK,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after the pointer, wrapping.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] pointer,
  output logic             hit,
  output logic [IDX_W-1:0] index
);

  logic [7:0] best;

  // Distance from pointer+1 ranks candidates; the smallest eligible distance wins.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    best  = 8'(N);
    for (int unsigned i = 0; i < N; i++) begin
      if (eligible[i] && (8'((i + N - 1 - 32'(pointer)) % N) < best)) begin
        hit   = 1'b1;
        index = IDX_W'(i);
        best  = 8'((i + N - 1 - 32'(pointer)) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART transmitter among NUM_REQ byte streams.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      locked,
  output logic                      err_timeout
);

  arb_state_t        state, next_state;
  logic [ID_W-1:0]   pointer;
  logic [CNT_W-1:0]  burst_cnt;
  logic [CNT_W-1:0]  to_cnt;
  logic              last_r;

  logic [NUM_REQ-1:0] eligible;
  logic               pick_hit;
  logic [ID_W-1:0]    pick_idx;
  logic [BYTE_W-1:0]  sel_byte;
  logic               sel_last;
  logic               accept;
  logic               drop_lock;
  logic               set_err;

  // While a packet lock is held only the owner may be picked.
  always_comb begin
    eligible = req_valid;
    if (locked) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        eligible[i] = req_valid[i] && (ID_W'(i) == grant_id);
      end
    end
  end

  rr_pick #(
    .N    (NUM_REQ),
    .IDX_W(ID_W)
  ) u_pick (
    .eligible(eligible),
    .pointer (pointer),
    .hit     (pick_hit),
    .index   (pick_idx)
  );

  always_comb begin
    sel_byte = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == pick_idx) begin
        sel_byte = req_data[i*BYTE_W +: BYTE_W];
        sel_last = req_last[i];
      end
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    drop_lock  = 1'b0;
    set_err    = 1'b0;
    tx_start   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!reset && !tx_busy && pick_hit) begin
          accept     = 1'b1;
          next_state = START;
        end
      end
      START: begin
        tx_start   = 1'b1;
        next_state = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          next_state = WAIT_DONE;
        end else if ((to_cnt + CNT_W'(1)) == CNT_W'(ACK_TIMEOUT)) begin
          set_err    = 1'b1;
          drop_lock  = 1'b1;
          next_state = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          drop_lock  = last_r || (burst_cnt == CNT_W'(MAX_BURST));
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (ID_W'(i) == pick_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pointer     <= ID_W'(NUM_REQ - 1);
      burst_cnt   <= '0;
      to_cnt      <= '0;
      last_r      <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      locked      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= next_state;
      if (state == START) begin
        to_cnt <= '0;
      end else if (state == WAIT_ACK && !tx_busy) begin
        to_cnt <= to_cnt + CNT_W'(1);
      end
      if (accept) begin
        tx_data   <= sel_byte;
        last_r    <= sel_last;
        grant_id  <= pick_idx;
        locked    <= 1'b1;
        burst_cnt <= burst_cnt + CNT_W'(1);
      end
      if (drop_lock) begin
        locked    <= 1'b0;
        burst_cnt <= '0;
        pointer   <= grant_id;
      end
      if (set_err) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: two arbiter instances (default and MAX_BURST=2) with simple UART busy models.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instance A: default parameters
  logic [1:0]  a_valid = '0, a_last = '0, a_ready;
  logic [15:0] a_data = '0;
  logic        a_start, a_locked, a_err;
  logic        a_busy = 1'b0;
  logic [7:0]  a_txd;
  logic [1:0]  a_gid;

  // Instance B: MAX_BURST = 2
  logic [1:0]  b_valid = '0, b_last = '0, b_ready;
  logic [15:0] b_data = '0;
  logic        b_start, b_locked, b_err;
  logic        b_busy = 1'b0;
  logic [7:0]  b_txd;
  logic [1:0]  b_gid;

  uart_tx_arbiter dut_a (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_data(a_data), .req_last(a_last),
    .req_ready(a_ready), .tx_start(a_start), .tx_data(a_txd), .tx_busy(a_busy),
    .grant_id(a_gid), .locked(a_locked), .err_timeout(a_err)
  );

  uart_tx_arbiter #(.MAX_BURST(2)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_data(b_data), .req_last(b_last),
    .req_ready(b_ready), .tx_start(b_start), .tx_data(b_txd), .tx_busy(b_busy),
    .grant_id(b_gid), .locked(b_locked), .err_timeout(b_err)
  );

  // Byte streams: bit 8 = last flag
  logic [8:0]  a_q0[$], a_q1[$], b_q0[$], b_q1[$];
  int          a_idx0 = 0, a_idx1 = 0, b_idx0 = 0, b_idx1 = 0;
  logic [15:0] a_log[$], b_log[$];
  logic        a_noack = 1'b0;
  int a_bcnt = 0, b_bcnt = 0;
  int cyc = 0, a_rdy_cyc = 0, a_st_cnt = 0, a_st_cyc = 0, a_err_cyc = 0;
  logic [7:0] a_st_data = '0;
  logic       a_err_d = 1'b0;

  // UART models: busy rises the cycle after tx_start and stays high 10 cycles
  always @(posedge clk) begin
    if (a_bcnt > 0) begin
      a_bcnt <= a_bcnt - 1;
      if (a_bcnt == 1) a_busy <= 1'b0;
    end else if (a_start && !a_noack) begin
      a_busy <= 1'b1;
      a_bcnt <= 10;
    end
  end

  always @(posedge clk) begin
    if (b_bcnt > 0) begin
      b_bcnt <= b_bcnt - 1;
      if (b_bcnt == 1) b_busy <= 1'b0;
    end else if (b_start) begin
      b_busy <= 1'b1;
      b_bcnt <= 10;
    end
  end

  // Requester drivers present the next unaccepted byte
  always @(negedge clk) begin
    #1;
    a_valid[0] = (a_idx0 < a_q0.size());
    a_data[7:0] = a_valid[0] ? a_q0[a_idx0][7:0] : 8'h00;
    a_last[0] = a_valid[0] && a_q0[a_idx0][8];
    a_valid[1] = (a_idx1 < a_q1.size());
    a_data[15:8] = a_valid[1] ? a_q1[a_idx1][7:0] : 8'h00;
    a_last[1] = a_valid[1] && a_q1[a_idx1][8];
    b_valid[0] = (b_idx0 < b_q0.size());
    b_data[7:0] = b_valid[0] ? b_q0[b_idx0][7:0] : 8'h00;
    b_last[0] = b_valid[0] && b_q0[b_idx0][8];
    b_valid[1] = (b_idx1 < b_q1.size());
    b_data[15:8] = b_valid[1] ? b_q1[b_idx1][7:0] : 8'h00;
    b_last[1] = b_valid[1] && b_q1[b_idx1][8];
  end

  // Monitors log accepted bytes as {requester, byte}
  always @(posedge clk) begin
    if (reset) begin
      a_idx0 = 0; a_idx1 = 0; a_log.delete();
      a_rdy_cyc = 0; a_st_cnt = 0; a_err_d = 1'b0;
      b_idx0 = 0; b_idx1 = 0; b_log.delete();
    end else begin
      if (a_valid[0] && a_ready[0]) begin a_log.push_back({8'h00, a_data[7:0]});  a_idx0++; end
      if (a_valid[1] && a_ready[1]) begin a_log.push_back({8'h01, a_data[15:8]}); a_idx1++; end
      if (a_ready != 2'b00) a_rdy_cyc++;
      if (a_start) begin a_st_cnt++; a_st_data = a_txd; a_st_cyc = cyc; end
      if (a_err && !a_err_d) a_err_cyc = cyc;
      a_err_d = a_err;
      if (b_valid[0] && b_ready[0]) begin b_log.push_back({8'h00, b_data[7:0]});  b_idx0++; end
      if (b_valid[1] && b_ready[1]) begin b_log.push_back({8'h01, b_data[15:8]}); b_idx1++; end
    end
    cyc++;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    a_q0.delete(); a_q1.delete(); b_q0.delete(); b_q1.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_a_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(a_idx0 >= a_q0.size() && a_idx1 >= a_q1.size() && !a_locked &&
                 !a_busy && !a_start) && n < 500);
    check(tag, 32'(n < 500), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_a_busy(input string tag);
    int n = 0;
    while (!a_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 100), 32'd1);
  endtask

  logic [15:0] exp_alt[4]   = '{16'h00A0, 16'h01B0, 16'h00A1, 16'h01B1};
  logic [15:0] exp_pkt[4]   = '{16'h0110, 16'h0111, 16'h0112, 16'h0020};
  logic [15:0] exp_burst[6] = '{16'h00C0, 16'h00C1, 16'h01D0, 16'h00C2, 16'h00C3, 16'h00C4};

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_start", 32'(a_start), 32'd0);
    check("rst_data",  32'(a_txd),   32'd0);
    check("rst_gid",   32'(a_gid),   32'd0);
    check("rst_lock",  32'(a_locked), 32'd0);
    check("rst_err",   32'(a_err),   32'd0);
    reset = 1'b0;

    // Single byte from requester 0
    a_q0.push_back({1'b1, 8'h41});
    wait_a_busy("t1_wait_busy");
    check("t1_locked_busy", 32'(a_locked), 32'd1);
    wait_a_idle("t1_wait_idle");
    check("t1_log",       32'(a_log[0]), 32'h0041);
    check("t1_ready_cyc", 32'(a_rdy_cyc), 32'd1);
    check("t1_starts",    32'(a_st_cnt), 32'd1);
    check("t1_tx_data",   32'(a_st_data), 32'h41);
    check("t1_gid",       32'(a_gid), 32'd0);
    check("t1_unlocked",  32'(a_locked), 32'd0);

    // Both requesters, single-byte packets: strict alternation
    do_reset();
    a_q0.push_back({1'b1, 8'hA0}); a_q0.push_back({1'b1, 8'hA1});
    a_q1.push_back({1'b1, 8'hB0}); a_q1.push_back({1'b1, 8'hB1});
    wait_a_idle("t2_wait_idle");
    check("t2_count", 32'(a_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("t2_order%0d", k), 32'(a_log[k]), 32'(exp_alt[k]));

    // Requester 1 packet holds the lock against requester 0
    do_reset();
    a_q1.push_back({1'b0, 8'h10}); a_q1.push_back({1'b0, 8'h11}); a_q1.push_back({1'b1, 8'h12});
    repeat (2) @(negedge clk);
    a_q0.push_back({1'b1, 8'h20});
    wait_a_idle("t3_wait_idle");
    check("t3_count", 32'(a_log.size()), 32'd4);
    for (int k = 0; k < 4; k++) check($sformatf("t3_order%0d", k), 32'(a_log[k]), 32'(exp_pkt[k]));

    // Transmitter never acknowledges
    do_reset();
    a_noack = 1'b1;
    a_q0.push_back({1'b1, 8'h55});
    wait_a_idle("t5_wait_idle");
    check("t5_err",      32'(a_err), 32'd1);
    check("t5_latency",  32'(a_err_cyc - a_st_cyc), 32'd9);
    check("t5_unlocked", 32'(a_locked), 32'd0);
    a_noack = 1'b0;
    a_q0.push_back({1'b1, 8'h66});
    wait_a_idle("t5_wait_idle2");
    check("t5_starts",   32'(a_st_cnt), 32'd2);
    check("t5_tx_data",  32'(a_st_data), 32'h66);
    check("t5_err_sticky", 32'(a_err), 32'd1);

    // Reset during WAIT_DONE of a multi-byte packet
    do_reset();
    a_q0.push_back({1'b0, 8'h30}); a_q0.push_back({1'b0, 8'h31}); a_q0.push_back({1'b1, 8'h32});
    wait_a_busy("t6_wait_busy");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    a_q0.delete();
    @(negedge clk);
    check("t6_ready", 32'(a_ready), 32'd0);
    check("t6_start", 32'(a_start), 32'd0);
    check("t6_data",  32'(a_txd),   32'd0);
    check("t6_gid",   32'(a_gid),   32'd0);
    check("t6_lock",  32'(a_locked), 32'd0);
    check("t6_err",   32'(a_err),   32'd0);
    a_q1.push_back({1'b1, 8'h77});
    a_q0.push_back({1'b1, 8'h78});
    @(negedge clk);
    reset = 1'b0;
    wait_a_idle("t6_wait_idle");
    check("t6_first",  32'(a_log[0]), 32'h0078);
    check("t6_second", 32'(a_log[1]), 32'h0177);

    // MAX_BURST = 2 forces release mid-packet
    do_reset();
    for (int k = 0; k < 5; k++) b_q0.push_back({1'b0, 8'(8'hC0 + k)});
    b_q1.push_back({1'b1, 8'hD0});
    n = 0;
    while (b_log.size() < 6 && n < 800) begin
      @(negedge clk);
      n++;
    end
    check("t4_wait_bytes", 32'(n < 800), 32'd1);
    repeat (15) @(negedge clk);
    check("t4_count", 32'(b_log.size()), 32'd6);
    for (int k = 0; k < 6; k++) check($sformatf("t4_order%0d", k), 32'(b_log[k]), 32'(exp_burst[k]));
    check("t4_lock_held", 32'(b_locked), 32'd1);
    check("t4_gid",       32'(b_gid),    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the SoC's single UART transmitter (the TXD path) between NUM_REQ byte-stream requesters, e.g. CPU console and LED/status monitor.
- Round-robin arbitration with per-packet lock: a granted requester keeps the UART until it sends a byte flagged last, or until MAX_BURST bytes have been sent.
- Sequences the UART TX core through a start/busy handshake and detects a non-responding transmitter with a timeout.

Parameters:
- NUM_REQ, 2, number of requesters (legal range 2..4).
- ID_W, 2, width of grant_id; must satisfy 2^ID_W >= NUM_REQ.
- MAX_BURST, 16, maximum bytes per grant before forced release (legal range 1..255).
- ACK_TIMEOUT, 8, cycles allowed in WAIT_ACK for tx_busy to rise (legal range 1..255).

Ports:
- clk  in  1  system clock (single clock domain).
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  in  NUM_REQ  byte is the final byte of the requester's packet.
- req_ready  out  NUM_REQ  byte accepted this cycle; one-hot or zero.
- tx_start  out  1  one-cycle pulse to the UART TX core.
- tx_data  out  8  byte to transmit; stable from START until the return to IDLE.
- tx_busy  in  1  UART TX core busy.
- grant_id  out  ID_W  current or last owner.
- locked  out  1  a packet lock is held.
- err_timeout  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset values:
  - state = IDLE; req_ready = 0; tx_start = 0; tx_data = 0; grant_id = 0; locked = 0; err_timeout = 0.
  - Burst counter = 0; round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- Reset mid-transfer aborts immediately. No tx_start is issued after reset. The UART core may still finish its current byte.
- Handshake:
  - A byte is transferred when req_valid[i] & req_ready[i].
  - req_ready is combinational from state, locked, owner, tx_busy and req_valid.
  - req_ready is asserted only in IDLE with tx_busy = 0.
  - Requesters must hold req_valid, req_data and req_last stable until accepted.
- IDLE:
  - If locked, only the owner is eligible; other requesters wait even if valid.
  - If not locked, pick the first valid requester scanning pointer+1, pointer+2, ... modulo NUM_REQ.
  - On a pick g: req_ready[g] = 1; capture the byte into tx_data and last into last_r; grant_id <= g; locked <= 1; increment the burst counter; go to START.
  - If nothing is eligible, stay in IDLE.
- START: tx_start = 1 for exactly this cycle; clear the timeout counter; go to WAIT_ACK.
- WAIT_ACK:
  - tx_busy = 1: go to WAIT_DONE.
  - Otherwise increment the timeout counter. When it reaches ACK_TIMEOUT: err_timeout <= 1; release (see below); go to IDLE.
  - Start-to-release latency on timeout is ACK_TIMEOUT+1 cycles after the tx_start cycle.
- WAIT_DONE: tx_busy = 0 → go to IDLE.
  - Release if last_r = 1 or burst counter = MAX_BURST.
  - Otherwise keep the lock and the burst count.
- Release: locked <= 0; burst counter <= 0; pointer <= grant_id.
- Owner throughput: minimum 4 cycles + UART byte time per byte. The next byte's accept can occur in the same cycle WAIT_DONE returns to IDLE.
- Boundary cases:
  - Owner deasserts valid while locked: lock holds indefinitely, by design; the packet owner must finish.
  - Simultaneous valid on all inputs with no lock: pointer order decides.
  - MAX_BURST = 1 gives pure byte-level round-robin.
  - req_last and MAX_BURST reached together: a single release.
  - tx_busy already high in IDLE: no accept until it falls.
  - Burst counter width is 8 bits and cannot overflow (MAX_BURST <= 255).

Decomposition:
- Shared package uart_arb_pkg holds:
  - state enum: IDLE, START, WAIT_ACK, WAIT_DONE;
  - BYTE_W = 8;
  - counter width constant CNT_W = 8.
- One sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: eligible mask, pointer.
  - Outputs: hit, index.
  - Reusable by future bus arbiters.

Test Plan:
- Reset then req_valid = 01, data 0x41, last = 1; UART model raises busy 1 cycle after start for 10 cycles → req_ready = 01 for one cycle, tx_start one pulse, tx_data = 0x41, locked drops after busy falls, grant_id = 0.
- Both requesters valid continuously, every byte last = 1 → grants alternate 0,1,0,1 across 4 bytes; no requester is served twice in a row.
- Requester 1 sends a 3-byte packet (0x10, 0x11, 0x12 with last on 0x12) while requester 0 is valid → all 3 bytes go out before any requester-0 byte; the next grant is 0.
- MAX_BURST = 2, requester 0 streams 5 bytes with no last, requester 1 valid → order is 0,0,1,0,0,0 (requester 1's byte carries last).
- UART model never raises busy → err_timeout = 1 exactly ACK_TIMEOUT+1 cycles after tx_start; state returns to IDLE and the lock is released. A later byte still issues a tx_start, and err_timeout stays 1.
- Assert reset in WAIT_DONE mid-packet → next cycle all outputs are at reset values; after release, requester 0 wins first.
